// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module      : ram_arbiter
//  Description : Round-robin arbiter sharing one single-port RAM among REQ
//                requesters, with read data routed back to the issuer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter #(
  parameter  int REQ    = 4,
  parameter  int DATA   = 16,
  parameter  int DEPTH  = 4,
  parameter  int RD_LAT = 0,
  localparam int ADDR   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int ID     = $clog2(REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REQ-1:0]            req,
  input  logic [REQ-1:0]            req_rw_,
  input  logic [REQ-1:0][ADDR-1:0]  req_addr,
  input  logic [REQ-1:0][DATA-1:0]  req_wdata,
  output logic [REQ-1:0]            gnt,
  output logic [REQ-1:0]            rsp_valid,
  output logic [DATA-1:0]           rsp_data,
  output logic                      ram_en,
  output logic                      ram_rw_,
  output logic [ADDR-1:0]           ram_addr,
  output logic [DATA-1:0]           ram_wdata,
  input  logic [DATA-1:0]           ram_rdata
);

  localparam int STAGES = RD_LAT + 1;

  logic [ID-1:0]              r_ptr;
  logic [ID-1:0]              w_win;
  logic                       w_any;
  logic [REQ-1:0]             w_gnt;
  logic [ID-1:0]              w_ptr_nxt;
  logic [STAGES-1:0]          r_pv;
  logic [STAGES-1:0][ID-1:0]  r_pid;
  logic                       w_last_v;

  // First set request at or after the pointer, wrapping modulo REQ.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_win = '0;
    w_gnt = '0;
    idx   = 0;
    for (int k = 0; k < REQ; k++) begin
      idx = (int'(r_ptr) + k) % REQ;
      if (!w_any && req[idx]) begin
        w_any = 1'b1;
        w_win = ID'(idx);
      end
    end
    if (w_any && !reset) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  assign gnt       = w_gnt;
  assign w_ptr_nxt = (w_win == ID'(REQ - 1)) ? '0 : w_win + ID'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // RAM port: payload registers hold their value when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_en    <= 1'b0;
      ram_rw_   <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= w_any;
      if (w_any) begin
        ram_rw_   <= req_rw_[w_win];
        ram_addr  <= req_addr[w_win];
        ram_wdata <= req_wdata[w_win];
      end
    end
  end

  // Requester-id pipeline, tagged with read-valid, aligned to RAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv  <= '0;
      r_pid <= '0;
    end else begin
      r_pv[0]  <= w_any & req_rw_[w_win];
      r_pid[0] <= w_win;
      for (int s = 1; s < STAGES; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pid[s] <= r_pid[s-1];
      end
    end
  end

  assign w_last_v = r_pv[STAGES-1];
  assign rsp_data = w_last_v ? ram_rdata : '0;

  generate
    for (genvar i = 0; i < REQ; i++) begin : g_rsp
      assign rsp_valid[i] = w_last_v && (r_pid[STAGES-1] == ID'(i));
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed, table-driven bench for ram_arbiter with a small
//                single-port RAM model (output register enabled).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  localparam int REQ    = 4;
  localparam int DATA   = 16;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 1;
  localparam int ADDR   = 2;
  localparam int NVEC   = 31;

  logic                      clk;
  logic                      reset;
  logic [REQ-1:0]            req;
  logic [REQ-1:0]            req_rw_;
  logic [REQ-1:0][ADDR-1:0]  req_addr;
  logic [REQ-1:0][DATA-1:0]  req_wdata;
  logic [REQ-1:0]            gnt;
  logic [REQ-1:0]            rsp_valid;
  logic [DATA-1:0]           rsp_data;
  logic                      ram_en;
  logic                      ram_rw_;
  logic [ADDR-1:0]           ram_addr;
  logic [DATA-1:0]           ram_wdata;
  logic [DATA-1:0]           ram_rdata;

  int checks   = 0;
  int failures = 0;

  ram_arbiter #(
    .REQ    (REQ),
    .DATA   (DATA),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_rw_   (req_rw_),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_en    (ram_en),
    .ram_rw_   (ram_rw_),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: writes land at the edge ending the access cycle, reads are
  // registered (one cycle of latency).
  logic            preload;
  logic [DATA-1:0] mem [DEPTH];
  logic [DATA-1:0] rdata_q;

  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 16'h1111;
      mem[1] <= 16'h2222;
      mem[2] <= 16'hBEEF;
      mem[3] <= 16'h3333;
    end else if (ram_en) begin
      if (ram_rw_) rdata_q <= mem[ram_addr];
      else         mem[ram_addr] <= ram_wdata;
    end
  end

  assign ram_rdata = rdata_q;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rw;
    logic [7:0]  addr;
    logic [3:0]  gnt;
    logic        en;
    logic [3:0]  rv;
    logic [15:0] rd;
    logic        chk;
    logic        rw_o;
    logic [1:0]  a_o;
    logic [15:0] wd_o;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //           req      rw      addr   gnt      en  rv       rd        chk rw_o a_o  wd_o
    vecs[0]  = '{4'b0001, 4'hF, 8'hE6, 4'b0001, 0, 4'b0000, 16'h0000, 1, 1, 2'd0, 16'h0000};
    vecs[1]  = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 1, 4'b0000, 16'h0000, 1, 1, 2'd2, 16'hD000};
    vecs[2]  = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b0001, 16'hBEEF, 0, 1, 2'd0, 16'h0000};
    vecs[3]  = '{4'b1000, 4'hF, 8'h24, 4'b1000, 0, 4'b0000, 16'h0000, 0, 1, 2'd0, 16'h0000};
    vecs[4]  = '{4'b1111, 4'hF, 8'hE4, 4'b0001, 1, 4'b0000, 16'h0000, 1, 1, 2'd0, 16'hD003};
    vecs[5]  = '{4'b1111, 4'hF, 8'hE4, 4'b0010, 1, 4'b1000, 16'h1111, 0, 1, 2'd0, 16'h0000};
    vecs[6]  = '{4'b1111, 4'hF, 8'hE4, 4'b0100, 1, 4'b0001, 16'h1111, 0, 1, 2'd0, 16'h0000};
    vecs[7]  = '{4'b1111, 4'hF, 8'hE4, 4'b1000, 1, 4'b0010, 16'h2222, 0, 1, 2'd0, 16'h0000};
    vecs[8]  = '{4'b1111, 4'hF, 8'hE4, 4'b0001, 1, 4'b0100, 16'hBEEF, 0, 1, 2'd0, 16'h0000};
    vecs[9]  = '{4'b1111, 4'hF, 8'hE4, 4'b0010, 1, 4'b1000, 16'h3333, 0, 1, 2'd0, 16'h0000};
    vecs[10] = '{4'b1111, 4'hF, 8'hE4, 4'b0100, 1, 4'b0001, 16'h1111, 0, 1, 2'd0, 16'h0000};
    vecs[11] = '{4'b1111, 4'hF, 8'hE4, 4'b1000, 1, 4'b0010, 16'h2222, 0, 1, 2'd0, 16'h0000};
    vecs[12] = '{4'b1010, 4'hF, 8'hE4, 4'b0010, 1, 4'b0100, 16'hBEEF, 0, 1, 2'd0, 16'h0000};
    vecs[13] = '{4'b1000, 4'hF, 8'hE4, 4'b1000, 1, 4'b1000, 16'h3333, 0, 1, 2'd0, 16'h0000};
    vecs[14] = '{4'b0010, 4'hD, 8'hEC, 4'b0010, 1, 4'b0010, 16'h2222, 0, 1, 2'd0, 16'h0000};
    vecs[15] = '{4'b0100, 4'hF, 8'hF4, 4'b0100, 1, 4'b1000, 16'h3333, 1, 0, 2'd3, 16'h1234};
    vecs[16] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 1, 4'b0000, 16'h0000, 1, 1, 2'd3, 16'hD002};
    vecs[17] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b0100, 16'h1234, 0, 1, 2'd0, 16'h0000};
    vecs[18] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b0000, 16'h0000, 1, 1, 2'd3, 16'hD002};
    vecs[19] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b0000, 16'h0000, 0, 1, 2'd0, 16'h0000};
    vecs[20] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b0000, 16'h0000, 0, 1, 2'd0, 16'h0000};
    vecs[21] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b0000, 16'h0000, 0, 1, 2'd0, 16'h0000};
    vecs[22] = '{4'b1111, 4'hF, 8'hE4, 4'b1000, 0, 4'b0000, 16'h0000, 0, 1, 2'd0, 16'h0000};
    vecs[23] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 1, 4'b0000, 16'h0000, 1, 1, 2'd3, 16'hD003};
    vecs[24] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b1000, 16'h1234, 0, 1, 2'd0, 16'h0000};
    vecs[25] = '{4'b0100, 4'hF, 8'hE4, 4'b0100, 0, 4'b0000, 16'h0000, 0, 1, 2'd0, 16'h0000};
    vecs[26] = '{4'b0100, 4'hF, 8'hE4, 4'b0100, 1, 4'b0000, 16'h0000, 0, 1, 2'd0, 16'h0000};
    vecs[27] = '{4'b0100, 4'hF, 8'hE4, 4'b0100, 1, 4'b0100, 16'hBEEF, 0, 1, 2'd0, 16'h0000};
    vecs[28] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 1, 4'b0100, 16'hBEEF, 0, 1, 2'd0, 16'h0000};
    vecs[29] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b0100, 16'hBEEF, 0, 1, 2'd0, 16'h0000};
    vecs[30] = '{4'b0000, 4'hF, 8'hE4, 4'b0000, 0, 4'b0000, 16'h0000, 0, 1, 2'd0, 16'h0000};

    reset     = 1'b1;
    preload   = 1'b1;
    req       = 4'b1111;
    req_rw_   = 4'hF;
    req_addr  = 8'hE4;
    req_wdata = {16'hD003, 16'hD002, 16'h1234, 16'hD000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_gnt",       0, 32'(gnt),       32'h0);
    check("rst_ram_en",    0, 32'(ram_en),    32'h0);
    check("rst_ram_rw",    0, 32'(ram_rw_),   32'h1);
    check("rst_ram_addr",  0, 32'(ram_addr),  32'h0);
    check("rst_ram_wdata", 0, 32'(ram_wdata), 32'h0);
    check("rst_rsp_valid", 0, 32'(rsp_valid), 32'h0);
    check("rst_rsp_data",  0, 32'(rsp_data),  32'h0);

    reset   = 1'b0;
    preload = 1'b0;
    req     = 4'b0000;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      req      = vecs[i].req;
      req_rw_  = vecs[i].rw;
      req_addr = vecs[i].addr;
      #1;
      check("gnt",       i, 32'(gnt),       32'(vecs[i].gnt));
      check("ram_en",    i, 32'(ram_en),    32'(vecs[i].en));
      check("rsp_valid", i, 32'(rsp_valid), 32'(vecs[i].rv));
      check("rsp_data",  i, 32'(rsp_data),  32'(vecs[i].rd));
      if (vecs[i].chk) begin
        check("ram_rw",    i, 32'(ram_rw_),   32'(vecs[i].rw_o));
        check("ram_addr",  i, 32'(ram_addr),  32'(vecs[i].a_o));
        check("ram_wdata", i, 32'(ram_wdata), 32'(vecs[i].wd_o));
      end
    end

    // Read granted, then reset lands while the read is in flight.
    @(negedge clk);
    req      = 4'b0001;
    req_rw_  = 4'hF;
    req_addr = 8'hE6;
    #1;
    check("mid_gnt", 100, 32'(gnt), 32'b0001);
    @(negedge clk);
    #1;
    check("mid_issue", 101, 32'(ram_en), 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rsp_valid", 102, 32'(rsp_valid), 32'h0);
    check("mid_ram_en",    102, 32'(ram_en),    32'h0);
    check("mid_gnt_rst",   102, 32'(gnt),       32'h0);
    check("mid_rsp_data",  102, 32'(rsp_data),  32'h0);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("post_rsp_valid", 103 + c, 32'(rsp_valid), 32'h0);
      check("post_ram_en",    103 + c, 32'(ram_en),    32'h0);
    end
    @(negedge clk);
    req = 4'b1111;
    #1;
    check("post_ptr", 106, 32'(gnt), 32'b0001);
    @(negedge clk);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
